// File: rtl/dcp_pkg.sv
// dcp_pkg: shared state type, window height and column-group packing for the dark-channel window sequencer
package dcp_pkg;
  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
  localparam int K = 3;
  localparam int PIX_W = 8;
  localparam int MAX_DW = 32;
  function automatic logic [K*MAX_DW-1:0] pack_group(input logic [MAX_DW-1:0] top, input logic [MAX_DW-1:0] mid,
                                                     input logic [MAX_DW-1:0] bot, input int dw);
    return ((K*MAX_DW)'(bot) << (2*dw)) | ((K*MAX_DW)'(mid) << dw) | (K*MAX_DW)'(top);
  endfunction
endpackage

// File: rtl/dcp_window_ctrl_if.sv
// dcp_window_ctrl_if: pixel input stream and column-group output stream of the window sequencer
interface dcp_window_ctrl_if
  import dcp_pkg::*;
#(
  parameter int DW = PIX_W
);
  logic [DW-1:0]   i_pix;
  logic            i_valid;
  logic            o_ready;
  logic [K*DW-1:0] o_group;
  logic            o_valid;
  logic            i_ready;
  logic            o_last;
  logic            o_frame_done;
  modport slave (input i_pix, i_valid, i_ready, output o_ready, o_group, o_valid, o_last, o_frame_done);
  modport master (output i_pix, i_valid, i_ready, input o_ready, o_group, o_valid, o_last, o_frame_done);
endinterface

// File: rtl/dcp_line_buffer.sv
// dcp_line_buffer: one image row of pixels, single write port and combinational read at the same column
module dcp_line_buffer #(
  parameter int DEPTH = 640,
  parameter int DW = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [DEPTH];
  always_ff @(posedge i_clk)
    if (i_we) r_mem[i_addr] <= i_wdata;
  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/dcp_window_ctrl.sv
// dcp_window_ctrl: turns a raster pixel stream into K=3 vertical column groups with top/bottom row replication
module dcp_window_ctrl
  import dcp_pkg::*;
#(
  parameter int DW = PIX_W,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input logic i_clk,
  input logic i_rst,
  dcp_window_ctrl_if.slave bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  state_t          r_state;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic [K*DW-1:0] r_group;
  logic            r_valid;
  logic            r_last;
  logic            r_done;
  logic [DW-1:0]   w_lb0;
  logic [DW-1:0]   w_lb1;
  logic [DW-1:0]   w_top;
  logic            w_free;
  logic            w_ready;
  logic            w_acc;
  logic            w_col_end;
  logic            w_row_end;
  logic            w_flush_ld;
  assign w_free     = !r_valid || bus.i_ready;
  assign w_ready    = r_state == RUN ? w_free : r_state != FLUSH;
  assign w_acc      = bus.i_valid && w_ready;
  assign w_col_end  = r_col == CW'(IMG_W - 1);
  assign w_row_end  = r_row == RW'(IMG_H - 1);
  assign w_top      = r_row == RW'(1) ? w_lb1 : w_lb0;
  // the final group stays parked until handed off, so no further FLUSH loads
  assign w_flush_ld = r_state == FLUSH && w_free && !r_last;
  dcp_line_buffer #(.DEPTH(IMG_W), .DW(DW)) u_lb0 (
    .i_clk  (i_clk),
    .i_we   (w_acc && r_state == RUN),
    .i_addr (r_col),
    .i_wdata(w_lb1),
    .o_rdata(w_lb0)
  );
  dcp_line_buffer #(.DEPTH(IMG_W), .DW(DW)) u_lb1 (
    .i_clk  (i_clk),
    .i_we   (w_acc),
    .i_addr (r_col),
    .i_wdata(bus.i_pix),
    .o_rdata(w_lb1)
  );
  assign bus.o_ready      = w_ready;
  assign bus.o_group      = r_group;
  assign bus.o_valid      = r_valid;
  assign bus.o_last       = r_last;
  assign bus.o_frame_done = r_done;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_col   <= '0;
      r_row   <= '0;
      r_group <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_valid && bus.i_ready) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
      case (r_state)
        IDLE: if (w_acc) begin
          r_col   <= CW'(1);
          r_state <= FILL;
        end
        FILL: if (w_acc) begin
          r_col <= w_col_end ? '0 : r_col + 1'b1;
          if (w_col_end) begin
            r_row   <= RW'(1);
            r_state <= RUN;
          end
        end
        RUN: if (w_acc) begin
          r_valid <= 1'b1;
          r_last  <= 1'b0;
          r_group <= (K*DW)'(pack_group(MAX_DW'(w_top), MAX_DW'(w_lb1), MAX_DW'(bus.i_pix), DW));
          r_col   <= w_col_end ? '0 : r_col + 1'b1;
          if (w_col_end && w_row_end) r_state <= FLUSH;
          else if (w_col_end) r_row <= r_row + 1'b1;
        end
        FLUSH: if (w_flush_ld) begin
          r_valid <= 1'b1;
          r_last  <= w_col_end;
          r_group <= (K*DW)'(pack_group(MAX_DW'(w_lb0), MAX_DW'(w_lb1), MAX_DW'(w_lb1), DW));
          r_col   <= w_col_end ? '0 : r_col + 1'b1;
        end else if (r_last && bus.i_ready) begin
          r_state <= IDLE;
          r_done  <= 1'b1;
          r_row   <= '0;
          r_col   <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcp_window_ctrl.sv
// tb_dcp_window_ctrl: directed checks of the window sequencer on a 4x3 frame with pixel(r,c)=16*r+c
module tb_dcp_window_ctrl;
  localparam int W = 4;
  localparam int H = 3;
  logic clk;
  logic rst;
  int total = 0;
  int bad = 0;
  int pr, pc, pf, pf_lim;
  int gr, gc, ng, ndone;
  logic exp_done;
  dcp_window_ctrl_if #(.DW(8)) bus ();
  dcp_window_ctrl #(.DW(8), .IMG_W(W), .IMG_H(H)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [23:0] exp_group(input int r, input int c);
    int tr, br;
    tr = r == 0 ? 0 : r - 1;
    br = r == H - 1 ? H - 1 : r + 1;
    return {8'(16 * br + c), 8'(16 * r + c), 8'(16 * tr + c)};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask
  task automatic clr();
    pr = 0; pc = 0; pf = 0; pf_lim = 1;
    gr = 0; gc = 0; ng = 0; ndone = 0;
    exp_done = 1'b0;
  endtask
  task automatic step(input logic want, input logic rdy, input logic rs);
    @(negedge clk);
    rst = rs;
    bus.i_valid = want && (pf < pf_lim);
    bus.i_pix = 8'(16 * pr + pc);
    bus.i_ready = rdy;
    #1;
    if (!rs) begin
      chk("frame_done", 32'(bus.o_frame_done), 32'(exp_done));
      if (exp_done) begin
        ndone++;
        chk("groups_per_frame", ng, W * H);
        ng = 0;
        exp_done = 1'b0;
      end
      if (bus.i_valid && bus.o_ready) begin
        if (pr == 0 && pc == 0 && pf > 0) chk("accept_after_done", ndone, pf);
        pc++;
        if (pc == W) begin
          pc = 0; pr++;
          if (pr == H) begin pr = 0; pf++; end
        end
      end
      if (bus.o_valid && rdy) begin
        chk("group", 32'(bus.o_group), 32'(exp_group(gr, gc)));
        chk("last", 32'(bus.o_last), 32'(gr == H - 1 && gc == W - 1));
        if (gr == 0 && gc == 0) chk("group_0_0", 32'(bus.o_group), 32'h100000);
        if (gr == 1 && gc == 2) chk("group_1_2", 32'(bus.o_group), 32'h221202);
        if (gr == 2 && gc == 3) chk("group_2_3", 32'(bus.o_group), 32'h232313);
        if (gr == H - 1 && gc == W - 1) exp_done = 1'b1;
        ng++;
        gc++;
        if (gc == W) begin
          gc = 0; gr++;
          if (gr == H) gr = 0;
        end
      end
    end
  endtask
  task automatic run_until_done(input logic gaps, input int target);
    int n;
    n = 0;
    while (ndone < target && n < 200) begin
      step(gaps ? n % 2 == 0 : 1'b1, 1'b1, 1'b0);
      n++;
    end
    chk("frame_timeout", 32'(ndone >= target), 32'd1);
  endtask
  initial begin
    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_pix = '0;
    bus.i_ready = 1'b1;
    clr();
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_last", 32'(bus.o_last), 32'd0);
    chk("rst_group", 32'(bus.o_group), 32'd0);
    chk("rst_ready", 32'(bus.o_ready), 32'd1);
    // continuous frame: 4 fill clocks, 8 RUN groups, 4 FLUSH groups, done pulse
    clr();
    for (int i = 1; i <= 18; i++) begin
      step(1'b1, 1'b1, 1'b0);
      chk("c1_valid", 32'(bus.o_valid), 32'(i >= 6 && i <= 17));
      chk("c1_ready", 32'(bus.o_ready), 32'(!(i >= 13 && i <= 17)));
    end
    chk("c1_frames", ndone, 1);
    // backpressure for 3 clocks while group (1,1) is presented
    clr();
    for (int i = 1; i <= 10; i++) step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0);
      chk("stall_group", 32'(bus.o_group), 32'h211101);
      chk("stall_valid", 32'(bus.o_valid), 32'd1);
      chk("stall_ready", 32'(bus.o_ready), 32'd0);
    end
    run_until_done(1'b0, 1);
    // input gaps every other cycle
    clr();
    run_until_done(1'b1, 1);
    // reset while pixel (1,2) is being accepted
    clr();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    clr();
    step(1'b0, 1'b1, 1'b0);
    chk("abort_valid", 32'(bus.o_valid), 32'd0);
    chk("abort_ready", 32'(bus.o_ready), 32'd1);
    chk("abort_last", 32'(bus.o_last), 32'd0);
    run_until_done(1'b0, 1);
    // two back-to-back frames with input always offered
    clr();
    pf_lim = 2;
    run_until_done(1'b0, 2);
    chk("b2b_pixels", pf, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
